// File: rtl/sdp_bram_be.sv
// Simple-dual-port block RAM with byte write enables, 1/2-cycle read latency and a self-clearing init sweep.
// Optional feature macro: SDP_BRAM_BE_FWD_EN (same-address write-to-read forwarding; default is read-first).
module sdp_bram_be #(
    parameter int               WIDTH      = 32,
    parameter int               DEPTH      = 512,
    parameter int               RD_LATENCY = 1,
    parameter logic [WIDTH-1:0] INIT_VAL   = {WIDTH{1'b0}},
    localparam int              NB         = WIDTH / 8,
    localparam int              AW         = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [NB-1:0]    wr_be,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             init_busy
);

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ONE_A     = AW'(1'b1);

    state_t           state_r;
    logic [AW-1:0]    cnt_r;
    logic             init_busy_r;
    logic [WIDTH-1:0] mem_r [DEPTH];

    logic             run_s;
    logic             wr_ok_s;
    logic             rd_ok_s;
    logic             rd_in_range_s;
    logic             mem_we_s;
    logic [AW-1:0]    mem_waddr_s;
    logic [NB-1:0]    mem_wbe_s;
    logic [WIDTH-1:0] mem_wdata_s;

    logic             s1_valid_r;
    logic [WIDTH-1:0] s1_data_r;
    logic [WIDTH-1:0] s1_merged_s;

    // Init sequencer: sweep every address once after reset, then hand the RAM to normal traffic.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= ST_INIT;
            cnt_r       <= {AW{1'b0}};
            init_busy_r <= 1'b1;
        end else begin
            case (state_r)
                ST_INIT: begin
                    if (cnt_r == LAST_ADDR) begin
                        state_r     <= ST_RUN;
                        cnt_r       <= {AW{1'b0}};
                        init_busy_r <= 1'b0;
                    end else begin
                        cnt_r       <= cnt_r + ONE_A;
                    end
                end
                ST_RUN: begin
                    state_r     <= ST_RUN;
                    init_busy_r <= 1'b0;
                end
                default: begin
                    state_r     <= ST_INIT;
                    cnt_r       <= {AW{1'b0}};
                    init_busy_r <= 1'b1;
                end
            endcase
        end
    end

    // Request qualification and write-port mux; the sequencer owns the port until RUN.
    always_comb begin
        run_s         = (state_r == ST_RUN);
        wr_ok_s       = run_s && wr_en && ({1'b0, wr_addr} < DEPTH_W);
        rd_ok_s       = run_s && rd_en;
        rd_in_range_s = ({1'b0, rd_addr} < DEPTH_W);
        if (run_s) begin
            mem_we_s    = wr_ok_s;
            mem_waddr_s = wr_addr;
            mem_wbe_s   = wr_be;
            mem_wdata_s = wr_data;
        end else begin
            mem_we_s    = 1'b1;
            mem_waddr_s = cnt_r;
            mem_wbe_s   = {NB{1'b1}};
            mem_wdata_s = INIT_VAL;
        end
    end

    // RAM array: left unreset so it maps onto block RAM; byte lanes are written independently.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            for (int i = 0; i < NB; i++) begin
                if (mem_wbe_s[i]) begin
                    mem_r[mem_waddr_s][8*i +: 8] <= mem_wdata_s[8*i +: 8];
                end
            end
        end
    end

    // Stage 1: synchronous read (pre-write content); holes above DEPTH read as zero.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid_r <= 1'b0;
            s1_data_r  <= {WIDTH{1'b0}};
        end else begin
            s1_valid_r <= rd_ok_s;
            if (rd_ok_s && rd_in_range_s) begin
                s1_data_r <= mem_r[rd_addr];
            end else if (rd_ok_s) begin
                s1_data_r <= {WIDTH{1'b0}};
            end else begin
                s1_data_r <= s1_data_r;
            end
        end
    end

`ifdef SDP_BRAM_BE_FWD_EN
    logic             fwd_hit_s;
    logic [NB-1:0]    s1_fwd_be_r;
    logic [WIDTH-1:0] s1_fwd_data_r;

    assign fwd_hit_s = wr_ok_s && rd_ok_s && (wr_addr == rd_addr);

    // Forward mask/data ride alongside stage 1 so the merge adds no latency.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_fwd_be_r   <= {NB{1'b0}};
            s1_fwd_data_r <= {WIDTH{1'b0}};
        end else if (rd_ok_s) begin
            s1_fwd_be_r   <= fwd_hit_s ? wr_be : {NB{1'b0}};
            s1_fwd_data_r <= wr_data;
        end else begin
            s1_fwd_be_r   <= s1_fwd_be_r;
            s1_fwd_data_r <= s1_fwd_data_r;
        end
    end

    // Lane merge: forwarded lanes take the same-cycle write data.
    always_comb begin
        s1_merged_s = s1_data_r;
        for (int i = 0; i < NB; i++) begin
            if (s1_fwd_be_r[i]) begin
                s1_merged_s[8*i +: 8] = s1_fwd_data_r[8*i +: 8];
            end else begin
                s1_merged_s[8*i +: 8] = s1_data_r[8*i +: 8];
            end
        end
    end
`else
    assign s1_merged_s = s1_data_r;
`endif

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic             out_valid_r;
            logic [WIDTH-1:0] out_data_r;

            // Output register: second read stage, holds data between reads.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    out_valid_r <= 1'b0;
                    out_data_r  <= {WIDTH{1'b0}};
                end else begin
                    out_valid_r <= s1_valid_r;
                    if (s1_valid_r) begin
                        out_data_r <= s1_merged_s;
                    end else begin
                        out_data_r <= out_data_r;
                    end
                end
            end

            assign rd_valid = out_valid_r;
            assign rd_data  = out_data_r;
        end else begin : g_lat1
            assign rd_valid = s1_valid_r;
            assign rd_data  = s1_merged_s;
        end
    endgenerate

    assign init_busy = init_busy_r;

endmodule

// File: tb/tb_sdp_bram_be.sv
// Bench for sdp_bram_be: two instances (latency 1 and 2, DEPTH=12) share stimulus and are checked
// against an array-based reference model of the memory and its read latency.
module tb_sdp_bram_be;

    localparam int          D  = 12;
    localparam logic [31:0] IV = 32'hA5A5A5A5;
`ifdef SDP_BRAM_BE_FWD_EN
    localparam logic        FWD    = 1'b1;
    localparam logic [31:0] SC_EXP = 32'hDEADBEEF;
    localparam logic [31:0] PC_EXP = 32'h0123CCDD;
`else
    localparam logic        FWD    = 1'b0;
    localparam logic [31:0] SC_EXP = 32'h00000000;
    localparam logic [31:0] PC_EXP = 32'h01234567;
`endif

    logic        clk;
    logic        rstn    = 1'b0;
    logic        wr_en   = 1'b0;
    logic        rd_en   = 1'b0;
    logic [3:0]  wr_addr = 4'h0;
    logic [3:0]  rd_addr = 4'h0;
    logic [3:0]  wr_be   = 4'h0;
    logic [31:0] wr_data = 32'h0;
    logic [31:0] rd_data1, rd_data2;
    logic        rd_valid1, rd_valid2, init_busy1, init_busy2;

    int total = 0;
    int bad   = 0;

    logic [31:0] ref_mem [D];
    logic        m1_v, m2_v;
    logic [31:0] m1_d, m2_d;

    sdp_bram_be #(.WIDTH(32), .DEPTH(D), .RD_LATENCY(1), .INIT_VAL(IV)) u_lat1 (
        .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1), .init_busy(init_busy1));

    sdp_bram_be #(.WIDTH(32), .DEPTH(D), .RD_LATENCY(2), .INIT_VAL(IV)) u_lat2 (
        .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data2), .rd_valid(rd_valid2), .init_busy(init_busy2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] ref_read(input logic [3:0] a, input logic we, input logic [3:0] wa,
                                             input logic [3:0] be, input logic [31:0] wd);
        logic [31:0] r;
        if (a >= D) return 32'h0;
        r = ref_mem[a];
        if (FWD && we && wa == a)
            for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < D; i++) ref_mem[i] = IV;
        m1_v = 1'b0; m2_v = 1'b0; m1_d = 32'h0; m2_d = 32'h0;
    endtask

    // One RUN-mode clock: drive request, advance the model, sample #1 after the edge.
    task automatic step(input logic we, input logic [3:0] wa, input logic [3:0] be, input logic [31:0] wd,
                        input logic re, input logic [3:0] ra);
        logic [31:0] rv;
        wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd; rd_en = re; rd_addr = ra;
        rv = ref_read(ra, we, wa, be, wd);
        if (we && wa < D)
            for (int i = 0; i < 4; i++) if (be[i]) ref_mem[wa][8*i +: 8] = wd[8*i +: 8];
        m2_v = m1_v;
        if (m1_v) m2_d = m1_d;
        m1_v = re;
        if (re) m1_d = rv;
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    // Hammer both ports during init and count edges until init_busy drops.
    task automatic wait_init(output int n, output logic saw_valid);
        n = 0; saw_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            wr_en = 1'b1; wr_addr = 4'($urandom_range(0, 11)); wr_be = 4'hF; wr_data = $urandom;
            rd_en = 1'b1; rd_addr = 4'($urandom_range(0, 11));
            @(posedge clk); #1;
            n++;
            if (rd_valid1 || rd_valid2 || (init_busy1 != init_busy2)) saw_valid = 1'b1;
            if (!init_busy1) break;
        end
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic test_reset();
        int n; logic sv;
        rstn = 1'b0; model_reset();
        repeat (3) @(posedge clk);
        #1;
        total++; if (rd_valid1 !== 1'b0 || rd_valid2 !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b/%b want 0/0", rd_valid1, rd_valid2); end
        total++; if (rd_data1 !== 32'h0 || rd_data2 !== 32'h0) begin bad++; $display("FAIL reset_data: got %h/%h want 0", rd_data1, rd_data2); end
        total++; if (init_busy1 !== 1'b1 || init_busy2 !== 1'b1) begin bad++; $display("FAIL reset_busy: got %b/%b want 1/1", init_busy1, init_busy2); end
        rstn = 1'b1;
        wait_init(n, sv);
        total++; if (n != D) begin bad++; $display("FAIL init_len: got %0d cycles want %0d", n, D); end
        total++; if (sv !== 1'b0) begin bad++; $display("FAIL init_quiet: got valid/busy-skew %b want 0", sv); end
        for (int a = 0; a < D; a++) begin
            step(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'(a));
            total++; if (rd_valid1 !== 1'b1 || rd_data1 !== IV || rd_valid2 !== 1'b0) begin bad++; $display("FAIL init_rd_l1 a=%0d: got v1=%b d1=%h v2=%b want 1 %h 0", a, rd_valid1, rd_data1, rd_valid2, IV); end
            step(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
            total++; if (rd_valid1 !== 1'b0 || rd_data1 !== IV || rd_valid2 !== 1'b1 || rd_data2 !== IV) begin bad++; $display("FAIL init_rd_l2 a=%0d: got v1=%b d1=%h v2=%b d2=%h want 0 %h 1 %h", a, rd_valid1, rd_data1, rd_valid2, rd_data2, IV, IV); end
        end
    endtask

    task automatic test_byte_enable();
        step(1'b1, 4'd3, 4'hF, 32'h11223344, 1'b0, 4'h0);
        step(1'b1, 4'd3, 4'b0101, 32'hFFEEDDCC, 1'b0, 4'h0);
        step(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd3);
        total++; if (rd_valid1 !== 1'b1 || rd_data1 !== 32'h11EE33CC) begin bad++; $display("FAIL be_merge_l1: got v=%b d=%h want 1 11ee33cc", rd_valid1, rd_data1); end
        step(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
        total++; if (rd_valid2 !== 1'b1 || rd_data2 !== 32'h11EE33CC) begin bad++; $display("FAIL be_merge_l2: got v=%b d=%h want 1 11ee33cc", rd_valid2, rd_data2); end
        step(1'b1, 4'd3, 4'h0, 32'h99999999, 1'b0, 4'h0);
        step(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd3);
        total++; if (rd_data1 !== 32'h11EE33CC) begin bad++; $display("FAIL be_zero_noop: got %h want 11ee33cc", rd_data1); end
    endtask

    task automatic test_same_cycle();
        step(1'b1, 4'd5, 4'hF, 32'h0, 1'b0, 4'h0);
        step(1'b1, 4'd6, 4'hF, 32'h01234567, 1'b0, 4'h0);
        step(1'b1, 4'd5, 4'hF, 32'hDEADBEEF, 1'b1, 4'd5);
        total++; if (rd_valid1 !== 1'b1 || rd_data1 !== SC_EXP) begin bad++; $display("FAIL same_cyc_l1: got %h want %h", rd_data1, SC_EXP); end
        step(1'b1, 4'd6, 4'b0011, 32'hAABBCCDD, 1'b1, 4'd6);
        total++; if (rd_valid2 !== 1'b1 || rd_data2 !== SC_EXP) begin bad++; $display("FAIL same_cyc_l2: got %h want %h", rd_data2, SC_EXP); end
        total++; if (rd_data1 !== PC_EXP) begin bad++; $display("FAIL partial_fwd_l1: got %h want %h", rd_data1, PC_EXP); end
        step(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd5);
        total++; if (rd_data2 !== PC_EXP) begin bad++; $display("FAIL partial_fwd_l2: got %h want %h", rd_data2, PC_EXP); end
        total++; if (rd_data1 !== 32'hDEADBEEF) begin bad++; $display("FAIL write_commit: got %h want deadbeef", rd_data1); end
        step(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd6);
        total++; if (rd_data1 !== 32'h0123CCDD) begin bad++; $display("FAIL partial_commit: got %h want 0123ccdd", rd_data1); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] wd [8];
        logic e1, e2;
        for (int i = 0; i < 8; i++) begin
            wd[i] = $urandom;
            step(1'b1, 4'(i), 4'hF, wd[i], 1'b0, 4'h0);
        end
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 4'h0, 4'h0, 32'h0, (k < 8), 4'(k));
            e1 = (k < 8);
            e2 = (k >= 1 && k <= 8);
            total++; if (rd_valid1 !== e1 || (e1 && rd_data1 !== wd[k])) begin bad++; $display("FAIL b2b_l1 k=%0d: got v=%b d=%h want v=%b", k, rd_valid1, rd_data1, e1); end
            total++; if (rd_valid2 !== e2 || (e2 && rd_data2 !== wd[k-1])) begin bad++; $display("FAIL b2b_l2 k=%0d: got v=%b d=%h want v=%b", k, rd_valid2, rd_data2, e2); end
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] snap [D];
        for (int i = 0; i < D; i++) snap[i] = ref_mem[i];
        step(1'b1, 4'd13, 4'hF, $urandom, 1'b0, 4'h0);
        step(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd13);
        total++; if (rd_valid1 !== 1'b1 || rd_data1 !== 32'h0) begin bad++; $display("FAIL oor_l1: got v=%b d=%h want 1 0", rd_valid1, rd_data1); end
        step(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
        total++; if (rd_valid2 !== 1'b1 || rd_data2 !== 32'h0) begin bad++; $display("FAIL oor_l2: got v=%b d=%h want 1 0", rd_valid2, rd_data2); end
        for (int a = 0; a < D; a++) begin
            step(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'(a));
            total++; if (rd_data1 !== snap[a]) begin bad++; $display("FAIL oor_intact a=%0d: got %h want %h", a, rd_data1, snap[a]); end
        end
    endtask

    task automatic test_random();
        logic we, re;
        logic [3:0] wa, ra, be;
        for (int k = 0; k < 400; k++) begin
            we = 1'($urandom_range(0, 1));
            re = 1'($urandom_range(0, 1));
            wa = 4'($urandom_range(0, 15));
            be = 4'($urandom);
            ra = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
            step(we, wa, be, $urandom, re, ra);
            total++; if (rd_valid1 !== m1_v || rd_data1 !== m1_d) begin bad++; $display("FAIL rand_l1 k=%0d: got v=%b d=%h want v=%b d=%h", k, rd_valid1, rd_data1, m1_v, m1_d); end
            total++; if (rd_valid2 !== m2_v || rd_data2 !== m2_d) begin bad++; $display("FAIL rand_l2 k=%0d: got v=%b d=%h want v=%b d=%h", k, rd_valid2, rd_data2, m2_v, m2_d); end
        end
    endtask

    task automatic test_reset_midburst();
        int n; logic sv;
        for (int i = 0; i < 4; i++) step(1'b1, 4'(i), 4'hF, $urandom, 1'b0, 4'h0);
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rd_addr = 4'(i);
            @(posedge clk); #1;
        end
        rd_addr = 4'd3;
        #2 rstn = 1'b0;
        #1;
        total++; if (rd_valid1 !== 1'b0 || rd_valid2 !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b/%b want 0/0", rd_valid1, rd_valid2); end
        total++; if (rd_data1 !== 32'h0 || rd_data2 !== 32'h0 || init_busy1 !== 1'b1 || init_busy2 !== 1'b1) begin bad++; $display("FAIL midrst_state: got d=%h/%h busy=%b/%b want 0 1", rd_data1, rd_data2, init_busy1, init_busy2); end
        @(posedge clk); #1;
        rd_en = 1'b0; rstn = 1'b1; model_reset();
        wait_init(n, sv);
        total++; if (n != D || sv !== 1'b0) begin bad++; $display("FAIL reinit_len: got %0d cycles quiet=%b want %0d 0", n, sv, D); end
        for (int a = 0; a < 4; a++) begin
            step(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'(a));
            total++; if (rd_valid1 !== 1'b1 || rd_data1 !== IV) begin bad++; $display("FAIL reinit_rd_l1 a=%0d: got %h want %h", a, rd_data1, IV); end
            step(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
            total++; if (rd_valid2 !== 1'b1 || rd_data2 !== IV) begin bad++; $display("FAIL reinit_rd_l2 a=%0d: got %h want %h", a, rd_data2, IV); end
        end
    endtask

    initial begin
        test_reset();
        test_byte_enable();
        test_same_cycle();
        test_back_to_back();
        test_out_of_range();
        test_random();
        test_reset_midburst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
